// File: rtl/line_ctrl_pkg.sv
// Shared types and constants for the line buffer controller.
package line_ctrl_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned NUM_LANES  = 4;

    typedef logic [NUM_LANES-1:0] strobe_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READY     = 2'd1,
        ST_REFILL    = 2'd2,
        ST_WRITEBACK = 2'd3
    } line_state_t;

endpackage

// File: rtl/line_beat_counter.sv
// Wrapping word index plus independent beat count for refill/writeback bursts.
// The index may start anywhere; the beat count always starts at zero, so
// o_last marks the final beat regardless of the starting word.
module line_beat_counter #(
    parameter int unsigned NUM_WORDS  = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_load_idx,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_idx,
    output logic                  o_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] r_cnt;

    // Load on burst start, otherwise step both index and count per beat
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_idx <= i_load_idx;
            r_cnt <= '0;
        end else if (i_advance) begin
            r_idx <= r_idx + ONE;
            r_cnt <= r_cnt + ONE;
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line buffer sequencer: arbitrates the LUTRAM write/address port between
// CPU hits, bus refill bursts and dirty writeback bursts, and tracks
// line valid/dirty state. NUM_BYTES must be 16, 32 or 64.
// Build option: LINE_CTRL_CRITICAL_WORD_EN starts refill at refill_first.
module line_buffer_ctrl
    import line_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_BYTES  = 64,
    localparam int unsigned NUM_WORDS  = NUM_BYTES / 4,
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  strobe_t               req_strobe,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [WORD_WIDTH-1:0] resp_data,
    output logic [WORD_WIDTH-1:0] resp_data_2,
    input  logic                  refill_start,
    input  logic [ADDR_WIDTH-1:0] refill_first,
    input  logic                  refill_valid,
    output logic                  refill_ready,
    input  logic [WORD_WIDTH-1:0] refill_data,
    input  logic                  refill_last,
    input  logic                  wb_start,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [WORD_WIDTH-1:0] wb_data,
    output logic                  wb_last,
    output logic                  line_valid,
    output logic                  line_dirty,
    output logic                  busy,
    output logic                  proto_err,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output strobe_t               ram_strobe,
    output logic [WORD_WIDTH-1:0] ram_wdata,
    input  logic [WORD_WIDTH-1:0] ram_rdata,
    input  logic [WORD_WIDTH-1:0] ram_rdata_2
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

    line_state_t r_state;
    line_state_t w_state_nxt;

    logic                  r_resp_valid;
    logic [WORD_WIDTH-1:0] r_resp_data;
    logic [WORD_WIDTH-1:0] r_resp_data_2;
    logic                  r_line_valid;
    logic                  r_line_dirty;
    logic                  r_proto_err;

    logic                  w_idle_or_ready;
    logic                  w_wb_go;
    logic                  w_refill_go;
    logic                  w_req_fire;
    logic                  w_refill_fire;
    logic                  w_wb_fire;
    logic [ADDR_WIDTH-1:0] w_refill_first_idx;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_cnt_last;

`ifdef LINE_CTRL_CRITICAL_WORD_EN
    assign w_refill_first_idx = refill_first;
`else
    logic w_unused_refill_first;
    assign w_refill_first_idx    = '0;
    assign w_unused_refill_first = ^refill_first;
`endif

    // Writeback outranks refill; writeback needs something dirty to flush
    assign w_idle_or_ready = (r_state == ST_IDLE) || (r_state == ST_READY);
    assign w_wb_go         = w_idle_or_ready && wb_start && r_line_dirty;
    assign w_refill_go     = w_idle_or_ready && refill_start && !w_wb_go;
    assign w_req_fire      = (r_state == ST_READY) && req_valid;
    assign w_refill_fire   = (r_state == ST_REFILL) && refill_valid;
    assign w_wb_fire       = (r_state == ST_WRITEBACK) && wb_ready;

    line_beat_counter #(
        .NUM_WORDS  (NUM_WORDS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_beat_counter (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_wb_go || w_refill_go),
        .i_load_idx (w_wb_go ? '0 : w_refill_first_idx),
        .i_advance  (w_refill_fire || w_wb_fire),
        .o_idx      (w_idx),
        .o_last     (w_cnt_last)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and RAM port / handshake drive per state
    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = 1'b0;
        refill_ready = 1'b0;
        wb_valid     = 1'b0;
        wb_last      = 1'b0;
        ram_en       = 1'b0;
        ram_addr     = w_idx;
        ram_strobe   = '0;
        ram_wdata    = req_wdata;
        case (r_state)
            ST_IDLE, ST_READY: begin
                if (r_state == ST_READY) begin
                    req_ready  = 1'b1;
                    ram_addr   = req_addr;
                    ram_strobe = req_strobe;
                    ram_en     = req_valid && (|req_strobe);
                end
                if (w_wb_go) begin
                    w_state_nxt = ST_WRITEBACK;
                end else if (w_refill_go) begin
                    w_state_nxt = ST_REFILL;
                end
            end
            ST_REFILL: begin
                refill_ready = 1'b1;
                ram_strobe   = '1;
                ram_wdata    = refill_data;
                ram_en       = refill_valid;
                if (refill_valid && w_cnt_last) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_WRITEBACK: begin
                wb_valid = 1'b1;
                wb_last  = (w_idx == LAST_IDX);
                if (wb_ready && (w_idx == LAST_IDX)) begin
                    w_state_nxt = ST_READY;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // CPU response capture; the RAM reads asynchronously, so sampling at the
    // write edge returns the pre-write contents
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
            r_resp_data_2 <= '0;
        end else begin
            r_resp_valid <= w_req_fire;
            if (w_req_fire) begin
                r_resp_data   <= ram_rdata;
                r_resp_data_2 <= ram_rdata_2;
            end
        end
    end

    // Line status: later assignments win, so a CPU write that coincides with a
    // burst start is still recorded before the burst outcome overrides it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_line_valid <= 1'b0;
            r_line_dirty <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            if (w_req_fire && (|req_strobe)) begin
                r_line_dirty <= 1'b1;
            end
            if (w_refill_go) begin
                r_line_valid <= 1'b0;
            end
            if (w_refill_fire && w_cnt_last) begin
                r_line_valid <= 1'b1;
                r_line_dirty <= 1'b0;
            end
            if (w_wb_fire && (w_idx == LAST_IDX)) begin
                r_line_dirty <= 1'b0;
            end
            if (w_refill_fire && (refill_last != w_cnt_last)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign resp_data_2 = r_resp_data_2;
    assign line_valid  = r_line_valid;
    assign line_dirty  = r_line_dirty;
    assign proto_err   = r_proto_err;
    assign busy        = (r_state == ST_REFILL) || (r_state == ST_WRITEBACK);
    assign wb_data     = ram_rdata;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with a behavioural LUTRAM attached.
module tb_line_buffer_ctrl;
    import line_ctrl_pkg::*;

    localparam int unsigned NB = 64;
    localparam int unsigned NW = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready;
    logic [3:0]  req_addr;
    logic [3:0]  req_strobe;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data, resp_data_2;
    logic        refill_start, refill_valid, refill_ready, refill_last;
    logic [3:0]  refill_first;
    logic [31:0] refill_data;
    logic        wb_start, wb_valid, wb_ready, wb_last;
    logic [31:0] wb_data;
    logic        line_valid, line_dirty, busy, proto_err;
    logic        ram_en;
    logic [3:0]  ram_addr, ram_addr_p1;
    logic [3:0]  ram_strobe;
    logic [31:0] ram_wdata, ram_rdata, ram_rdata_2;

    always #5 clk = ~clk;

    line_buffer_ctrl #(.NUM_BYTES(NB)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_strobe(req_strobe), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_data_2(resp_data_2),
        .refill_start(refill_start), .refill_first(refill_first),
        .refill_valid(refill_valid), .refill_ready(refill_ready),
        .refill_data(refill_data), .refill_last(refill_last),
        .wb_start(wb_start), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_last(wb_last),
        .line_valid(line_valid), .line_dirty(line_dirty), .busy(busy),
        .proto_err(proto_err),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_strobe(ram_strobe),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_rdata_2(ram_rdata_2)
    );

    // LUTRAM: byte-write, synchronous write, asynchronous dual read
    logic [31:0] ram_mem [NW];
    assign ram_addr_p1 = ram_addr + 4'd1;
    assign ram_rdata   = ram_mem[ram_addr];
    assign ram_rdata_2 = ram_mem[ram_addr_p1];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_strobe[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
    end

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    typedef struct packed { logic [31:0] d0; logic [31:0] d1; } resp_t;
    typedef struct packed { logic [31:0] d; logic l; } beat_t;
    resp_t       resp_q[$];
    beat_t       wb_q[$];
    logic [31:0] exp_line [NW];

    // Response scoreboard
    always @(negedge clk) begin
        resp_t e;
        if (resetn && resp_valid) begin
            if (resp_q.size() == 0) begin
                check1("resp_spurious", 1'b1, 1'b0);
            end else begin
                e = resp_q.pop_front();
                check32("resp_data", resp_data, e.d0);
                check32("resp_data_2", resp_data_2, e.d1);
            end
        end
    end

    // Writeback beat scoreboard plus hold-during-stall check
    logic        hold_pending = 1'b0;
    logic [31:0] hold_data;
    always @(negedge clk) begin
        beat_t e;
        if (hold_pending && wb_valid) check32("wb_hold", wb_data, hold_data);
        if (resetn && wb_valid && wb_ready) begin
            hold_pending <= 1'b0;
            if (wb_q.size() == 0) begin
                check1("wb_spurious", 1'b1, 1'b0);
            end else begin
                e = wb_q.pop_front();
                check32("wb_data", wb_data, e.d);
                check1("wb_last", wb_last, e.l);
            end
        end else if (resetn && wb_valid) begin
            hold_pending <= 1'b1;
            hold_data    <= wb_data;
            if (wb_q.size() != 0) check1("wb_last_stall", wb_last, wb_q[0].l);
        end else begin
            hold_pending <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_refill(input logic [3:0] first, input logic [31:0] base, input int early);
        int unsigned start;
`ifdef LINE_CTRL_CRITICAL_WORD_EN
        start = first;
`else
        start = 0;
`endif
        refill_start = 1'b1;
        refill_first = first;
        tick();
        refill_start = 1'b0;
        @(negedge clk);
        check1("refill_busy", busy, 1'b1);
        tick();
        for (int i = 0; i < 16; i++) begin
            refill_valid = 1'b1;
            refill_data  = base + 32'(i);
            refill_last  = (i == early);
            exp_line[(start + i) % NW] = base + 32'(i);
            @(negedge clk);
            check1("refill_ready", refill_ready, 1'b1);
            if (early != 15 && i == early)     check1("proto_err_before", proto_err, 1'b0);
            if (early != 15 && i == early + 1) check1("proto_err_set", proto_err, 1'b1);
            tick();
        end
        refill_valid = 1'b0;
        refill_last  = 1'b0;
        @(negedge clk);
        check1("refill_valid", line_valid, 1'b1);
        check1("refill_clean", line_dirty, 1'b0);
        check1("refill_idle", busy, 1'b0);
        check1("refill_req_ready", req_ready, 1'b1);
        tick();
    endtask

    task automatic do_req(input logic [3:0] addr, input logic [3:0] strobe, input logic [31:0] wdata);
        int unsigned a;
        a = addr;
        req_valid  = 1'b1;
        req_addr   = addr;
        req_strobe = strobe;
        req_wdata  = wdata;
        resp_q.push_back('{d0: exp_line[a], d1: exp_line[(a + 1) % NW]});
        for (int b = 0; b < 4; b++) begin
            if (strobe[b]) exp_line[a][b*8 +: 8] = wdata[b*8 +: 8];
        end
        @(negedge clk);
        check1("req_ready", req_ready, 1'b1);
        tick();
        req_valid  = 1'b0;
        req_strobe = 4'h0;
        @(negedge clk);
        check1("resp_valid", resp_valid, 1'b1);
        tick();
        @(negedge clk);
        check1("resp_pulse", resp_valid, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        resetn = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_strobe = '0; req_wdata = '0;
        refill_start = 1'b0; refill_first = '0; refill_valid = 1'b0;
        refill_data = '0; refill_last = 1'b0;
        wb_start = 1'b0; wb_ready = 1'b0;

        repeat (2) @(negedge clk);
        check1("rst_resp_valid", resp_valid, 1'b0);
        check32("rst_resp_data", resp_data, 32'h0);
        check32("rst_resp_data_2", resp_data_2, 32'h0);
        check1("rst_line_valid", line_valid, 1'b0);
        check1("rst_line_dirty", line_dirty, 1'b0);
        check1("rst_proto_err", proto_err, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_refill_ready", refill_ready, 1'b0);
        check1("rst_wb_valid", wb_valid, 1'b0);
        check1("rst_wb_last", wb_last, 1'b0);
        check1("rst_req_ready", req_ready, 1'b0);
        tick();
        resetn = 1'b1;
        tick();

        // Refill (critical word 5 only when the build option is on)
        do_refill(4'd5, 32'h100, 15);
        @(negedge clk);
        check1("refill_no_err", proto_err, 1'b0);
        tick();
        do_req(4'd15, 4'h0, 32'h0);
        do_req(4'd4, 4'h0, 32'h0);

        // Byte write returns old data, re-read shows merged word
        do_req(4'd3, 4'hF, 32'h1111_1111);
        do_req(4'd3, 4'b0010, 32'h0000_5500);
        do_req(4'd3, 4'h0, 32'h0);
        @(negedge clk);
        check1("dirty_after_write", line_dirty, 1'b1);
        tick();

        // Back-to-back reads, one response per cycle
        for (int i = 0; i < 4; i++) begin
            int unsigned a;
            a = i * 4 + 1;
            req_valid  = 1'b1;
            req_addr   = 4'(a);
            req_strobe = 4'h0;
            resp_q.push_back('{d0: exp_line[a], d1: exp_line[(a + 1) % NW]});
            tick();
        end
        req_valid = 1'b0;
        tick();
        tick();
        check32("b2b_drain", 32'(resp_q.size()), 32'd0);

        // Simultaneous starts while dirty: writeback wins
        for (int w = 0; w < 16; w++) wb_q.push_back('{d: exp_line[w], l: (w == 15)});
        wb_start = 1'b1;
        refill_start = 1'b1;
        tick();
        wb_start = 1'b0;
        refill_start = 1'b0;
        @(negedge clk);
        check1("wb_busy", busy, 1'b1);
        check1("wb_valid_on", wb_valid, 1'b1);
        check1("wb_not_refill", refill_ready, 1'b0);
        tick();
        k = 0;
        while (wb_q.size() > 0 && k < 64) begin
            wb_ready = (k % 2 == 0);
            tick();
            k++;
        end
        wb_ready = 1'b0;
        check32("wb_beats_done", 32'(wb_q.size()), 32'd0);
        @(negedge clk);
        check1("wb_end_busy", busy, 1'b0);
        check1("wb_end_dirty", line_dirty, 1'b0);
        check1("wb_end_valid", line_valid, 1'b1);
        check1("wb_end_wb_valid", wb_valid, 1'b0);
        tick();

        // Writeback request on a clean line is ignored
        wb_start = 1'b1;
        tick();
        wb_start = 1'b0;
        @(negedge clk);
        check1("clean_wb_ignored", busy, 1'b0);
        check1("clean_wb_ready", req_ready, 1'b1);
        tick();

        // Early last flag: error set, completion still by beat count
        do_refill(4'd0, 32'hC0, 7);
        @(negedge clk);
        check1("early_last_err", proto_err, 1'b1);
        tick();
        do_req(4'd2, 4'h0, 32'h0);
        @(negedge clk);
        check1("proto_err_sticky", proto_err, 1'b1);
        tick();

        // Reset in the middle of a refill
        refill_start = 1'b1;
        tick();
        refill_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            refill_valid = 1'b1;
            refill_data  = 32'hDEAD_0000 + 32'(i);
            tick();
        end
        resetn = 1'b0;
        refill_valid = 1'b0;
        #1;
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_refill_ready", refill_ready, 1'b0);
        check1("mid_rst_line_valid", line_valid, 1'b0);
        check1("mid_rst_line_dirty", line_dirty, 1'b0);
        check1("mid_rst_proto_err", proto_err, 1'b0);
        check1("mid_rst_resp_valid", resp_valid, 1'b0);
        check32("mid_rst_resp_data", resp_data, 32'h0);
        check32("mid_rst_resp_data_2", resp_data_2, 32'h0);
        check1("mid_rst_wb_valid", wb_valid, 1'b0);
        check1("mid_rst_wb_last", wb_last, 1'b0);
        tick();
        resetn = 1'b1;
        @(negedge clk);
        check1("post_rst_req_ready", req_ready, 1'b0);
        check1("post_rst_line_valid", line_valid, 1'b0);
        check1("post_rst_busy", busy, 1'b0);
        tick();
        check32("resp_queue_empty", 32'(resp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencer and access arbiter for one byte-writable, dual-read LUTRAM line buffer (16/32/64 bytes) inside the MIPS CPU cache path. Owns the RAM's single write/address port and shares it between three clients: CPU hits (read two consecutive words, byte-strobed writes), line refill from the bus (burst write), and dirty writeback (burst read). Tracks line valid/dirty state. The LUTRAM itself sits outside this block and connects through the `ram_*` ports.

## Interface
- `NUM_BYTES`, 64: line size; must be 16, 32 or 64.
- `NUM_WORDS`, derived: `NUM_BYTES/4`.
- `ADDR_WIDTH`, derived: `$clog2(NUM_WORDS)`.

Ports (clock and reset first):
- `clk` in 1: the only clock.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` / `req_ready` in / out 1: CPU access handshake.
- `req_addr` in ADDR_WIDTH: word index.
- `req_strobe` in 4: byte write enables; 0 means read.
- `req_wdata` in 32: write data.
- `resp_valid` out 1: response strobe.
- `resp_data` / `resp_data_2` out 32: word at `addr` and word at `addr+1` (mod `NUM_WORDS`).
- `refill_start` in 1: start a refill.
- `refill_first` in ADDR_WIDTH: critical word index.
- `refill_valid` / `refill_ready` in / out 1: refill beat handshake.
- `refill_data` in 32: beat data.
- `refill_last` in 1: last-beat flag.
- `wb_start` in 1: start a writeback.
- `wb_valid` / `wb_ready` out / in 1: writeback beat handshake.
- `wb_data` out 32: beat data.
- `wb_last` out 1: last-beat flag.
- `line_valid`, `line_dirty`, `busy`, `proto_err` out 1: status.
- `ram_en` out 1, `ram_addr` out ADDR_WIDTH, `ram_strobe` out 4, `ram_wdata` out 32: RAM drive.
- `ram_rdata`, `ram_rdata_2` in 32: asynchronous RAM read data.

## Operation
- States: IDLE (line invalid), READY (line valid), REFILL, WRITEBACK.
- In IDLE or READY:
  - `wb_start` → WRITEBACK, but only if `line_dirty`; otherwise it is ignored.
  - Else `refill_start` → REFILL.
  - When both are asserted, `wb_start` wins and `refill_start` is dropped.
  - Starts in any other state are ignored.
- READY:
  - `req_ready=1`, so a request is accepted the same cycle as `req_valid`.
  - `ram_addr=req_addr`, `ram_strobe=req_strobe`.
  - Read data is captured into `resp_data` / `resp_data_2` with read-before-write semantics: a write returns the old data.
  - Any nonzero strobe sets `line_dirty`.
  - A request accepted in the same cycle as a start commits before the new state takes effect.
- REFILL:
  - `refill_ready=1`.
  - Each accepted beat writes `refill_data` with strobe 4'hF at index `idx`, then `idx` increments mod `NUM_WORDS`.
  - After `NUM_WORDS` beats: → READY, `line_valid=1`, `line_dirty=0`.
  - If `refill_last` disagrees with the final-beat count, `proto_err` is set. It is sticky and cleared only by reset. The beat count alone governs completion.
- WRITEBACK:
  - `idx` starts at 0, `ram_addr=idx`, `ram_strobe=0`.
  - `wb_valid=1`, `wb_data=ram_rdata` (combinational).
  - `wb_last` is asserted when `idx==NUM_WORDS-1`.
  - `idx` advances on `wb_ready`.
  - After the last beat: → READY, `line_dirty=0`.
- `req_ready=0` in IDLE, REFILL and WRITEBACK.
- `busy` = state is REFILL or WRITEBACK.
- `ram_en=1` whenever a write is committed; it is don't-care otherwise.

## Timing
- Reset values:
  - state IDLE, `idx=0`.
  - `resp_valid`, `resp_data`, `resp_data_2`: all 0.
  - `line_valid`, `line_dirty`, `proto_err`, `busy`: all 0.
  - `refill_ready`, `wb_valid`, `wb_last`: all 0.
- Response latency: `resp_valid` pulses exactly one cycle after acceptance; back-to-back requests give one response per cycle.
- Start latency: the start is registered, so the first beat handshake can occur one cycle after the start pulse.
- Throughput: refill and writeback take one beat per cycle at full rate; `wb_valid` stays high and `wb_data` stays stable while `wb_ready=0`.
- Reset asserted mid-burst:
  - Immediate return to IDLE; line invalid, `proto_err` cleared.
  - RAM contents are undefined.

## Configuration
- `LINE_CTRL_CRITICAL_WORD_EN` defined: REFILL starts at `idx=refill_first` and wraps mod `NUM_WORDS`, so the critical word comes first.
- Undefined: REFILL always starts at `idx=0`, and `refill_first` is ignored.
- WRITEBACK always starts at 0 in both cases.

## Structure
- Package `line_ctrl_pkg`:
  - state enum `line_state_t`.
  - `WORD_WIDTH=32`, `NUM_LANES=4`.
  - `strobe_t` typedef.
- Sub-module `line_beat_counter`:
  - Wrapping `idx` plus a separate beat count.
  - Inputs: load value, advance.
  - Outputs: `idx`, `last`.
  - Shared by REFILL and WRITEBACK.

## Test plan
- **Refill from 0:** `NUM_BYTES=64`, macro off, `refill_start`, 16 beats of data `32'h100+i` with `refill_last` on beat 15 → `line_valid=1`, `dirty=0`, `proto_err=0`. Then a read at `addr=15` → `resp_data=32'h10F`, `resp_data_2=32'h100`.
- **Critical word first:** macro on, `refill_first=5`, beats `32'hA0+k` → word 5 = `32'hA0`, word 4 = `32'hAF`.
- **Byte write:** in READY, write `addr=3`, `strobe=4'b0010`, `wdata=32'h0000_5500` onto word `32'h1111_1111` → response returns `32'h1111_1111`. A re-read returns `32'h1111_5511`, and `line_dirty=1`.
- **Writeback with stalls and start priority:**
  - `wb_start` and `refill_start` pulsed together while dirty → WRITEBACK is entered.
  - Toggle `wb_ready` 1,0,1,… → 16 beats in order 0..15, `wb_data` held during stalls, `wb_last` only on word 15.
  - End state: READY, `dirty=0`.
- **Early last:** `refill_last` asserted on beat 7 of 16 → `proto_err=1`, refill still completes after 16 beats, and `proto_err` stays set until reset.
- **Reset mid-refill:** `resetn` pulled low after beat 4 → all outputs at reset values in the same cycle, state IDLE, and `req_ready=0` after release.
